// File: rtl/series_engine.sv
// Programmable power-series evaluator: y = sum_{k=1..N} c_k * x^k.
// Uses a Horner loop with one saturating multiply-accumulate per cycle.
module series_engine #(
    parameter int unsigned X_WIDTH    = 8,
    parameter int unsigned COEF_WIDTH = 16,
    parameter int unsigned COEF_FRAC  = 14,
    parameter int unsigned OUT_WIDTH  = 32,
    parameter int unsigned MAX_TERMS  = 8,
    parameter int unsigned N_WIDTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [N_WIDTH-1:0]    N,
    input  logic                  coef_we,
    input  logic [N_WIDTH-1:0]    coef_addr,
    input  logic [COEF_WIDTH-1:0] coef_data,
    input  logic                  x_valid,
    input  logic [X_WIDTH-1:0]    x_in,
    output logic                  ready,
    output logic [OUT_WIDTH-1:0]  y,
    output logic                  y_valid,
    output logic                  overflow,
    output logic                  error
);

    localparam int unsigned P_WIDTH = OUT_WIDTH + X_WIDTH;
    localparam int unsigned S_WIDTH = P_WIDTH + 1;

    if (COEF_FRAC >= COEF_WIDTH || MAX_TERMS >= (1 << N_WIDTH)) begin : g_bad_params
        $error("series_engine: inconsistent parameters");
    end

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CALC, S_OUT, S_ERR} state_t;

    state_t                       state_q, state_d;
    logic [N_WIDTH-1:0]           n_q, n_d, j_q, j_d;
    logic signed [X_WIDTH-1:0]    x_q, x_d;
    logic signed [OUT_WIDTH-1:0]  acc_q, acc_d, y_q, y_d;
    logic                         sticky_q, sticky_d, ovf_q, ovf_d;
    logic                         yv_q, yv_d, ready_q, ready_d, err_q, err_d;
    logic signed [COEF_WIDTH-1:0] coef_q [MAX_TERMS];
    logic signed [COEF_WIDTH-1:0] coef_d [MAX_TERMS];

    logic signed [COEF_WIDTH-1:0] c_top, c_next;
    logic [N_WIDTH-1:0]           next_idx;
    logic signed [P_WIDTH-1:0]    prod, shifted;
    logic signed [S_WIDTH-1:0]    sum;
    logic signed [OUT_WIDTH-1:0]  step_val;
    logic                         clip, coef_ok, n_valid;

    // Coefficient selection: c_N for the initial load, c_(N-j) (or 0 on the last step) per step
    always_comb begin
        next_idx = n_q - j_q;
        c_top    = '0;
        c_next   = '0;
        for (int unsigned k = 1; k <= MAX_TERMS; k++) begin
            if (n_q == N_WIDTH'(k)) c_top = coef_q[k-1];
            if (j_q < n_q && next_idx == N_WIDTH'(k)) c_next = coef_q[k-1];
        end
    end

    // One Horner step: floor-scaled product plus next coefficient, clipped to the output range
    always_comb begin
        prod     = P_WIDTH'(acc_q) * P_WIDTH'(x_q);
        shifted  = prod >>> (X_WIDTH - 1);
        sum      = S_WIDTH'(shifted) + S_WIDTH'(c_next);
        clip     = (sum[S_WIDTH-1:OUT_WIDTH-1] != {(S_WIDTH-OUT_WIDTH+1){sum[S_WIDTH-1]}});
        step_val = sum[OUT_WIDTH-1:0];
        if (clip) begin
            step_val = sum[S_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                      : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
    end

    // Coefficient bank is frozen while a sample is in flight
    always_comb begin
        coef_ok = coef_we && (state_q == S_IDLE || state_q == S_WAIT || state_q == S_ERR);
        for (int unsigned k = 1; k <= MAX_TERMS; k++) begin
            coef_d[k-1] = (coef_ok && coef_addr == N_WIDTH'(k)) ? coef_data : coef_q[k-1];
        end
    end

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        j_d      = j_q;
        x_d      = x_q;
        acc_d    = acc_q;
        sticky_d = sticky_q;
        y_d      = y_q;
        ovf_d    = ovf_q;
        yv_d     = 1'b0;
        err_d    = err_q;
        n_valid  = (N != '0) && (N <= N_WIDTH'(MAX_TERMS));

        case (state_q)
            S_WAIT: begin
                if (x_valid) begin
                    x_d      = x_in;
                    acc_d    = OUT_WIDTH'(c_top);
                    sticky_d = 1'b0;
                    j_d      = N_WIDTH'(1);
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                acc_d    = step_val;
                sticky_d = sticky_q | clip;
                if (j_q == n_q) begin
                    y_d     = step_val;
                    ovf_d   = sticky_q | clip;
                    yv_d    = 1'b1;
                    state_d = S_OUT;
                end else begin
                    j_d = j_q + N_WIDTH'(1);
                end
            end
            S_OUT:   state_d = S_WAIT;
            default: ;
        endcase

        // start overrides everything, discarding any sample in flight
        if (start) begin
            yv_d  = 1'b0;
            y_d   = y_q;
            ovf_d = ovf_q;
            if (n_valid) begin
                n_d     = N;
                err_d   = 1'b0;
                state_d = S_WAIT;
            end else begin
                err_d   = 1'b1;
                state_d = S_ERR;
            end
        end

        ready_d = (state_d == S_WAIT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            j_q      <= '0;
            x_q      <= '0;
            acc_q    <= '0;
            sticky_q <= 1'b0;
            y_q      <= '0;
            ovf_q    <= 1'b0;
            yv_q     <= 1'b0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            for (int unsigned k = 0; k < MAX_TERMS; k++) coef_q[k] <= '0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            j_q      <= j_d;
            x_q      <= x_d;
            acc_q    <= acc_d;
            sticky_q <= sticky_d;
            y_q      <= y_d;
            ovf_q    <= ovf_d;
            yv_q     <= yv_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            for (int unsigned k = 0; k < MAX_TERMS; k++) coef_q[k] <= coef_d[k];
        end
    end

    assign ready    = ready_q;
    assign y        = y_q;
    assign y_valid  = yv_q;
    assign overflow = ovf_q;
    assign error    = err_q;

endmodule

// File: tb/tb_series_engine.sv
// Bench for series_engine: a 32-bit and a 16-bit result instance share one stimulus stream
// and are compared against hand-derived vectors and a plain-arithmetic series model.
module tb_series_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  n_in;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [15:0] coef_data;
    logic        x_valid;
    logic [7:0]  x_in;

    logic        ready, y_valid, overflow, error;
    logic [31:0] y;
    logic        ready16, y_valid16, overflow16, error16;
    logic [15:0] y16;

    int tests = 0;
    int fails = 0;
    longint mc [1:8];
    longint last32, last16;

    always #5 clk = ~clk;

    series_engine dut (
        .clk(clk), .rst(rst), .start(start), .N(n_in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .x_valid(x_valid), .x_in(x_in),
        .ready(ready), .y(y), .y_valid(y_valid), .overflow(overflow), .error(error)
    );

    series_engine #(.OUT_WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start), .N(n_in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .x_valid(x_valid), .x_in(x_in),
        .ready(ready16), .y(y16), .y_valid(y_valid16), .overflow(overflow16), .error(error16)
    );

    typedef struct {
        int     c1, c2, c3;
        int     n;
        int     x;
        longint y32;
        bit     ov32;
        longint y16;
        bit     ov16;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Series value from the definition: Horner order with floor scaling and per-step clipping
    function automatic void model(input int n, input int x, input int ow,
                                  output longint yo, output bit ov);
        longint acc, p, hi, lo;
        hi  = (longint'(1) << (ow - 1)) - 1;
        lo  = -hi - 1;
        acc = mc[n];
        ov  = 1'b0;
        for (int j = 1; j <= n; j++) begin
            p = (acc * longint'(x)) >>> 7;
            if (j < n) p = p + mc[n-j];
            if (p > hi) begin p = hi; ov = 1'b1; end
            else if (p < lo) begin p = lo; ov = 1'b1; end
            acc = p;
        end
        yo = acc;
    endfunction

    task automatic write_coef(input int k, input int v);
        coef_we = 1'b1; coef_addr = 4'(k); coef_data = 16'(v);
        tick();
        coef_we = 1'b0;
        if (k >= 1 && k <= 8) mc[k] = longint'(v);
    endtask

    task automatic do_start(input int n);
        start = 1'b1; n_in = 4'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic run_sample(input string tag, input int n, input int x,
                              input longint e32, input bit o32,
                              input longint e16, input bit o16, input bit poke);
        int cyc;
        bit rdy_bad;
        check({tag, "_ready_before"}, longint'(ready), 1);
        x_valid = 1'b1; x_in = 8'(x);
        tick();
        x_valid = 1'b0;
        if (poke) begin coef_we = 1'b1; coef_addr = 4'd1; coef_data = 16'h1234; end
        cyc = 0;
        rdy_bad = 1'b0;
        do begin
            tick();
            coef_we = 1'b0;
            cyc++;
            if (ready) rdy_bad = 1'b1;
        end while (!y_valid && cyc < 20);
        check({tag, "_latency"}, longint'(cyc), longint'(n));
        check({tag, "_y32"}, longint'($signed(y)), e32);
        check({tag, "_ov32"}, longint'(overflow), longint'(o32));
        check({tag, "_y16"}, longint'($signed(y16)), e16);
        check({tag, "_ov16"}, longint'(overflow16), longint'(o16));
        check({tag, "_ready_busy"}, longint'(rdy_bad), 0);
        tick();
        check({tag, "_strobe_1cyc"}, longint'(y_valid), 0);
        check({tag, "_ready_after"}, longint'(ready), 1);
        check({tag, "_y_held"}, longint'($signed(y)), e32);
        last32 = e32;
        last16 = e16;
    endtask

    task automatic model_sample(input string tag, input int n, input int x, input bit poke);
        longint e32, e16;
        bit o32, o16;
        model(n, x, 32, e32, o32);
        model(n, x, 16, e16, o16);
        run_sample(tag, n, x, e32, o32, e16, o16, poke);
    endtask

    vec_t vecs [7];

    initial begin
        bit bad;
        rst = 1'b0; start = 1'b0; n_in = '0; coef_we = 1'b0; coef_addr = '0;
        coef_data = '0; x_valid = 1'b0; x_in = '0;
        for (int k = 1; k <= 8; k++) mc[k] = 0;
        last32 = 0; last16 = 0;

        vecs[0] = '{16384, 0, 0, 1, 64, 8192, 0, 8192, 0};
        vecs[1] = '{16384, 16384, 0, 2, 64, 12288, 0, 12288, 0};
        vecs[2] = '{16384, 16384, 0, 2, -64, -4096, 0, -4096, 0};
        vecs[3] = '{32767, 32767, 0, 2, 127, 64768, 0, 32511, 1};
        vecs[4] = '{32767, 32767, 0, 2, 0, 0, 0, 0, 0};
        vecs[5] = '{16384, -8192, 4096, 3, 64, 6656, 0, 6656, 0};
        vecs[6] = '{1, 0, 0, 1, -1, -1, 0, -1, 0};

        tick(); tick();
        check("rst_ready", longint'(ready), 0);
        check("rst_y", longint'(y), 0);
        check("rst_y_valid", longint'(y_valid), 0);
        check("rst_overflow", longint'(overflow), 0);
        check("rst_error", longint'(error), 0);
        rst = 1'b1;
        tick();
        check("idle_ready", longint'(ready), 0);

        // Directed vectors with hand-derived results
        for (int i = 0; i < 7; i++) begin
            write_coef(1, vecs[i].c1);
            write_coef(2, vecs[i].c2);
            write_coef(3, vecs[i].c3);
            do_start(vecs[i].n);
            run_sample($sformatf("vec%0d", i), vecs[i].n, vecs[i].x,
                       vecs[i].y32, vecs[i].ov32, vecs[i].y16, vecs[i].ov16, 1'b0);
        end

        // Invalid orders park the engine in the error state
        do_start(0);
        check("err_n0_error", longint'(error), 1);
        check("err_n0_ready", longint'(ready), 0);
        x_valid = 1'b1; x_in = 8'h40;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (y_valid || ready) bad = 1'b1;
        end
        x_valid = 1'b0;
        check("err_x_ignored", longint'(bad), 0);
        do_start(9);
        check("err_n9_error", longint'(error), 1);
        do_start(15);
        check("err_n15_error", longint'(error), 1);
        do_start(3);
        check("err_clear_error", longint'(error), 0);
        check("err_clear_ready", longint'(ready), 1);

        // Randomized orders, coefficients and samples against the model
        for (int it = 0; it < 30; it++) begin
            int n, x, gap;
            for (int k = 1; k <= 8; k++)
                write_coef(k, int'($signed(16'($urandom_range(0, 65535)))));
            if ($urandom_range(0, 3) == 0)
                write_coef(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(9, 15)),
                           int'($urandom_range(0, 65535)));
            n = int'($urandom_range(1, 8));
            x = int'($signed(8'($urandom_range(0, 255))));
            do_start(n);
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) tick();
            model_sample($sformatf("rnd%0d", it), n, x, 1'b0);
        end

        // Abort an N=8 sample on its third step; restart with N=2
        do_start(8);
        check("abort_ready0", longint'(ready), 1);
        x_valid = 1'b1; x_in = 8'h5A;
        tick();
        x_valid = 1'b0;
        tick(); tick();
        start = 1'b1; n_in = 4'd2;
        tick();
        start = 1'b0;
        check("abort_no_valid", longint'(y_valid), 0);
        check("abort_ready", longint'(ready), 1);
        check("abort_y_kept", longint'($signed(y)), last32);
        check("abort_y16_kept", longint'($signed(y16)), last16);
        model_sample("abort_new", 2, -77, 1'b0);

        // Coefficient write during CALC must not land
        write_coef(1, 16384);
        do_start(1);
        run_sample("prot_a", 1, 64, 8192, 0, 8192, 0, 1'b1);
        run_sample("prot_b", 1, 64, 8192, 0, 8192, 0, 1'b0);

        // Reset in the middle of a long evaluation
        do_start(8);
        x_valid = 1'b1; x_in = 8'h33;
        tick();
        x_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int k = 1; k <= 8; k++) mc[k] = 0;
        check("mid_rst_ready", longint'(ready), 0);
        check("mid_rst_y", longint'(y), 0);
        check("mid_rst_overflow", longint'(overflow), 0);
        check("mid_rst_error", longint'(error), 0);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (y_valid || ready) bad = 1'b1;
        end
        check("mid_rst_idle", longint'(bad), 0);
        do_start(1);
        run_sample("post_rst", 1, 64, 0, 0, 0, 0, 1'b0);

        // A write on the same edge as start still takes effect
        start = 1'b1; n_in = 4'd1;
        coef_we = 1'b1; coef_addr = 4'd1; coef_data = 16'd16384;
        tick();
        start = 1'b0; coef_we = 1'b0;
        run_sample("wr_with_start", 1, 64, 8192, 0, 8192, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/series_engine.md
Name: series_engine

Overview:
- Parametrised, programmable power-series evaluator: y = sum over k=1..N of c_k * x^k, in signed fixed point.
- Successor to the fixed-function series top: adds a run-time-loadable coefficient bank, generic widths and term count, saturating arithmetic, sticky per-sample overflow, and abort-on-start.
- Evaluates one sample at a time with an iterative Horner loop (one multiply-accumulate per cycle).
- Sits between the sample source (ready/valid handshake) and the result consumer.

Parameters:
X_WIDTH, 8, input sample width, signed Q1.(X_WIDTH-1)
COEF_WIDTH, 16, coefficient width, signed
COEF_FRAC, 14, fractional bits of coefficients and of y
OUT_WIDTH, 32, accumulator/result width, signed
MAX_TERMS, 8, maximum series order
N_WIDTH, 4, width of N; must hold MAX_TERMS+1

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-low
start  in  1  1-cycle pulse; latches N, aborts any evaluation
N  in  N_WIDTH  series order, sampled on start
coef_we  in  1  coefficient write strobe
coef_addr  in  N_WIDTH  coefficient index k, 1..MAX_TERMS
coef_data  in  COEF_WIDTH  c_k value
x_valid  in  1  sample present
x_in  in  X_WIDTH  sample
ready  out  1  engine accepts a sample this cycle
y  out  OUT_WIDTH  result, held until next result
y_valid  out  1  1-cycle result strobe
overflow  out  1  saturation occurred during the sample in y; held with y
error  out  1  invalid N latched

Behaviour:
- Reset (rst=0 at edge): state IDLE; ready=0, y=0, y_valid=0, overflow=0, error=0; all c_k=0; N register=0.
- States: IDLE, WAIT, CALC, OUT, ERR.
- start has priority in every state:
  - N in 1..MAX_TERMS -> latch N, go WAIT, clear error.
  - otherwise -> go ERR.
  - Start during CALC/OUT aborts the sample: no y_valid; y and overflow keep their previous values.
- IDLE: ready=0; waits for start.
- ERR: error=1, ready=0; x_valid is ignored; exits only on start or reset.
- WAIT: ready=1. On x_valid&&ready:
  - capture x;
  - acc <= sign-extended c_N;
  - clear sticky overflow;
  - step counter j <= 1;
  - go CALC.
- CALC (exactly N cycles), at step j:
  - p = acc*x, full width OUT_WIDTH+X_WIDTH;
  - arithmetic shift p right by X_WIDTH-1 (floor);
  - add c_(N-j) if j<N, else 0;
  - saturate to OUT_WIDTH signed range; any clip sets sticky overflow;
  - after step N go OUT.
- OUT: y_valid=1 for one cycle; y=acc and overflow=sticky, registered. Next state WAIT.
- Timing:
  - Accept edge t; steps at edges t+1..t+N.
  - y_valid is high in the cycle following edge t+N (latency N cycles after accept, y_valid observed N+1 cycles after the sample is presented).
  - ready is low from t+1 through the OUT cycle.
  - Throughput: one sample per N+2 cycles.
- Coefficient writes:
  - Accepted in IDLE, WAIT, ERR.
  - Ignored in CALC/OUT, so coefficients stay stable per sample.
  - coef_addr 0 or >MAX_TERMS is ignored.
  - A write on the same edge as start still takes effect.
- x_valid outside WAIT is ignored; no buffering.
- Reset mid-CALC: immediate return to IDLE, no y_valid, coefficients cleared.

Test Plan:
1. Basic: write c1=16384 (1.0), start N=1, x=0x40 (0.5) -> y=8192, overflow=0, y_valid 2 cycles after x is presented.
2. Horner: c1=c2=16384, N=2:
   - x=0x40 -> y=12288;
   - then x=0xC0 -> y=-4096;
   - ready low between samples, N+2 cycles per sample.
3. Saturation: OUT_WIDTH=16, c1=c2=32767, N=2, x=0x7F -> step1 clips to 32767, y=32511, overflow=1. The next sample x=0x00 -> y=0, overflow=0.
4. Error:
   - start N=0 -> error=1, ready=0, x_valid ignored;
   - start N=9 (MAX_TERMS=8) -> error=1;
   - then start N=3 -> error=0, ready=1.
5. Abort: start N=8, accept sample, pulse start N=2 on step 3 -> no y_valid for the aborted sample, ready=1 next cycle; the new sample is evaluated with N=2.
6. Protected writes and reset:
   - coef_we during CALC leaves the coefficient unchanged (verified by the next result);
   - rst=0 mid-CALC -> all outputs 0, state IDLE, prior coefficients read back as 0 (N=1 gives y=0).
